mips_mem_responder: RTL

- Memory-side responder for the single-cycle MIPS core's instruction and data ports.
- Serves combinational instruction fetch and data loads, and registered data stores.
- Owns program loading: holds the core in reset while a host streams a program into IMEM over a valid/ready handshake, then releases the core.
- Sits between the testbench/host loader and the core; it drives the core's reset.

---
 rtl/mips_mem_pkg.sv | 16 +
 rtl/mips_mem_array.sv | 25 ++
 rtl/mips_mem_responder.sv | 110 +++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and address helpers for the MIPS memory responder.
package mips_mem_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // True when a byte address falls inside a memory of 2**aw words.
  function automatic logic addr_in_range(input logic [31:0] addr, input int aw);
    return (addr >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Word-wide memory: one synchronous write port, one combinational read port.
// Reads above the array depth return zero instead of aliasing.
module mips_mem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic [31:2]           raddr,
  output logic [WORD_WIDTH-1:0] rdata
);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = addr_in_range({raddr, 2'b00}, AW) ? mem[raddr[AW+1:2]] : '0;

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the single-cycle MIPS core: IMEM/DMEM service,
// host program loading and core reset sequencing.
//
//   state | meaning
//   LOAD  | core held in reset, host streams words into IMEM
//   RUN   | core released, fetch/load/store served, cycles counted
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        core_rst_n,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        data_wr,
  output logic [31:0] data_in,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  input  logic        reload,
  output logic        run,
  output logic        err,
  output logic [31:0] cycle_cnt
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  state_t          state, state_next;
  logic [IAW-1:0]  ld_ptr;
  logic            fire;
  logic            ptr_full;
  logic            store_ok;
  logic            access_err;
  logic            dmem_we;

  assign fire     = (state == LOAD) && ld_valid;
  assign ptr_full = (ld_ptr == IAW'(IMEM_WORDS - 1));

  assign store_ok   = (data_addr[1:0] == 2'b00) && addr_in_range(data_addr, DAW);
  assign access_err = (inst_addr[1:0] != 2'b00) || (data_wr && !store_ok);
  assign dmem_we    = (state == RUN) && data_wr && store_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    run        = 1'b0;
    core_rst_n = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        if (fire && (ld_last || ptr_full)) state_next = RUN;
      end
      RUN: begin
        run        = 1'b1;
        core_rst_n = 1'b1;
        if (reload) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Pointer wraps to zero on the full-buffer fire; the FSM has left LOAD by then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_ptr    <= '0;
      err       <= 1'b0;
      cycle_cnt <= '0;
    end else if (state == LOAD) begin
      if (fire) ld_ptr <= ld_ptr + 1'b1;
    end else if (reload) begin
      ld_ptr    <= '0;
      err       <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      if (access_err) err <= 1'b1;
      if (cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  mips_mem_array #(.DEPTH(IMEM_WORDS)) u_imem (
    .clk   (clk),
    .we    (fire),
    .waddr (ld_ptr),
    .wdata (ld_data),
    .raddr (inst_addr[31:2]),
    .rdata (inst)
  );

  mips_mem_array #(.DEPTH(DMEM_WORDS)) u_dmem (
    .clk   (clk),
    .we    (dmem_we),
    .waddr (data_addr[DAW+1:2]),
    .wdata (data_out),
    .raddr (data_addr[31:2]),
    .rdata (data_in)
  );

endmodule
